// File: rtl/wptr_full_ctrl_if.sv
// Write-side FIFO controller bus: producer request, synchronized read pointer,
// and everything the controller publishes to the memory, the CDC and status.
interface wptr_full_ctrl_if #(
    parameter int ADDR_SIZE = 4
);
    logic                 winc;
    logic [ADDR_SIZE:0]   wq2_rptr;
    logic [ADDR_SIZE-1:0] waddr;
    logic                 wclk_en;
    logic                 wfull;
    logic [ADDR_SIZE:0]   wptr;
    logic [ADDR_SIZE:0]   wlevel;
    logic                 woverflow;
    logic                 walmost_full;

    // Producer / environment side
    modport master (
        output winc,
        output wq2_rptr,
        input  waddr,
        input  wclk_en,
        input  wfull,
        input  wptr,
        input  wlevel,
        input  woverflow,
        input  walmost_full
    );

    // Controller side
    modport slave (
        input  winc,
        input  wq2_rptr,
        output waddr,
        output wclk_en,
        output wfull,
        output wptr,
        output wlevel,
        output woverflow,
        output walmost_full
    );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Write pointer / full-flag controller for an async dual-port FIFO.
// Keeps a binary write pointer, publishes its Gray form for the read-domain
// synchronizer, and derives full, fill level and sticky overflow from the
// read pointer already synchronized into wclk.
// Optional: define WPTR_ALMOST_FULL_EN to enable the registered almost-full
// flag (level >= AFULL_THRESH); otherwise walmost_full is held at 0.
module wptr_full_ctrl #(
    parameter int ADDR_SIZE    = 4,
    parameter int AFULL_THRESH = (1 << ADDR_SIZE) - 2
) (
    input  logic           wclk,
    input  logic           wrst,
    wptr_full_ctrl_if.slave bus
);
    localparam int PW    = ADDR_SIZE + 1;
    localparam int DEPTH = 1 << ADDR_SIZE;

    // A threshold outside 0..DEPTH can never be met or is always met; such a
    // configuration leaves an empty marker block to flag it in the hierarchy.
    if (AFULL_THRESH < 0 || AFULL_THRESH > DEPTH) begin : g_afull_thresh_out_of_range
    end

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // XOR-prefix from the MSB down.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wfull_q, wfull_d;
    logic          woverflow_q, woverflow_d;
    logic          walmost_full_q, walmost_full_d;

    logic          wclk_en;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] full_match;

    // Write is accepted only when not full, so the array is never overrun.
    assign wclk_en = bus.winc & ~wfull_q;

    // Next pointer, full, level, overflow and almost-full for this edge.
    always_comb begin
        wbin_d      = wbin_q + PW'(wclk_en);
        wptr_d      = bin2gray(wbin_d);
        rbin_s      = gray2bin(bus.wq2_rptr);
        // Full when write is exactly one lap ahead: Gray form differs from
        // the read pointer in the top two bits only.
        full_match  = {~bus.wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], bus.wq2_rptr[ADDR_SIZE-2:0]};
        wfull_d     = (wptr_d == full_match);
        // Synchronized read pointer lags, so this never under-reports occupancy.
        wlevel_d    = wbin_d - rbin_s;
        woverflow_d = woverflow_q | (bus.winc & wfull_q);
`ifdef WPTR_ALMOST_FULL_EN
        walmost_full_d = (wlevel_d >= PW'(AFULL_THRESH));
`else
        walmost_full_d = 1'b0;
`endif
    end

    // Pointer and status registers; reset clears everything and ignores winc.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wfull_q        <= 1'b0;
            wlevel_q       <= '0;
            woverflow_q    <= 1'b0;
            walmost_full_q <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wfull_q        <= wfull_d;
            wlevel_q       <= wlevel_d;
            woverflow_q    <= woverflow_d;
            walmost_full_q <= walmost_full_d;
        end
    end

    assign bus.waddr        = wbin_q[ADDR_SIZE-1:0];
    assign bus.wclk_en      = wclk_en;
    assign bus.wfull        = wfull_q;
    assign bus.wptr         = wptr_q;
    assign bus.wlevel       = wlevel_q;
    assign bus.woverflow    = woverflow_q;
    assign bus.walmost_full = walmost_full_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl with ADDR_SIZE=4 (depth 16).
module tb_wptr_full_ctrl;
    localparam int AW = 4;
`ifdef WPTR_ALMOST_FULL_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wptr_full_ctrl_if #(.ADDR_SIZE(AW)) bus ();

    wptr_full_ctrl #(.ADDR_SIZE(AW), .AFULL_THRESH(14)) dut (
        .wclk (clk),
        .wrst (rst),
        .bus  (bus.slave)
    );

    typedef struct {
        string      name;
        logic       r;
        logic       w;
        logic [4:0] rq;
        logic [3:0] addr;
        logic [4:0] ptr;
        logic       full;
        logic [4:0] lvl;
        logic       ovf;
        logic       en;
        logic       af;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [4:0] g(input logic [4:0] b);
        return (b >> 1) ^ b;
    endfunction

    task automatic add(input string nm, input logic r, input logic w, input logic [4:0] rq,
                       input logic [3:0] a, input logic [4:0] p, input logic f,
                       input logic [4:0] l, input logic o, input logic en);
        vec_t v;
        v.name = nm; v.r = r; v.w = w; v.rq = rq; v.addr = a; v.ptr = p;
        v.full = f; v.lvl = l; v.ovf = o; v.en = en;
        v.af = AF_EN && (l >= 5'd14);
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [4:0] rq);
        @(negedge clk);
        rst          = r;
        bus.winc     = w;
        bus.wq2_rptr = rq;
        @(posedge clk);
        #1;
    endtask

    logic [4:0] prev;
    logic [4:0] wb;

    initial begin
        bus.winc     = 1'b0;
        bus.wq2_rptr = '0;

        // Test 1: reset, then 16 writes against an idle reader.
        add("t1_reset", 1, 1, 5'd0, 4'd0, 5'd0, 0, 5'd0, 0, 1);
        for (int k = 1; k <= 16; k++)
            add($sformatf("t1_wr%0d", k), 0, 1, 5'd0, 4'(k), g(5'(k)), (k == 16),
                5'(k), 0, (k < 16));
        // Test 2: write attempt while full, then idle; overflow sticks.
        add("t2_ovf_wr",   0, 1, 5'd0, 4'd0, 5'b11000, 1, 5'd16, 1, 0);
        add("t2_ovf_hold", 0, 0, 5'd0, 4'd0, 5'b11000, 1, 5'd16, 1, 0);
        // Test 3: reader frees one slot, one write refills it.
        add("t3_rd1",   0, 0, 5'b00001, 4'd0, 5'b11000, 0, 5'd15, 1, 0);
        add("t3_refill", 0, 1, 5'b00001, 4'd1, 5'b11001, 1, 5'd16, 1, 0);
        add("t3_rst",   1, 0, 5'b00001, 4'd0, 5'd0, 0, 5'd0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].w, tbl[i].rq);
            chk({tbl[i].name, "_waddr"},   32'(bus.waddr),        32'(tbl[i].addr));
            chk({tbl[i].name, "_wptr"},    32'(bus.wptr),         32'(tbl[i].ptr));
            chk({tbl[i].name, "_wfull"},   32'(bus.wfull),        32'(tbl[i].full));
            chk({tbl[i].name, "_wlevel"},  32'(bus.wlevel),       32'(tbl[i].lvl));
            chk({tbl[i].name, "_wovf"},    32'(bus.woverflow),    32'(tbl[i].ovf));
            chk({tbl[i].name, "_wclk_en"}, 32'(bus.wclk_en),      32'(tbl[i].en));
            chk({tbl[i].name, "_walmost"}, 32'(bus.walmost_full), 32'(tbl[i].af));
        end

        // Test 4: 20 writes past the wrap with the reader trailing by two.
        prev = bus.wptr;
        wb   = 5'd0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, g(wb - 5'd2));
            wb = wb + 5'd1;
            chk($sformatf("t4_gray_step%0d", k), 32'($countones(bus.wptr ^ prev)), 32'd1);
            chk($sformatf("t4_nofull%0d", k), 32'(bus.wfull), 32'd0);
            chk($sformatf("t4_level%0d", k), 32'(bus.wlevel), 32'd3);
            prev = bus.wptr;
        end
        chk("t4_waddr", 32'(bus.waddr), 32'd4);
        chk("t4_wptr",  32'(bus.wptr),  32'b11110);
        chk("t4_wovf",  32'(bus.woverflow), 32'd0);

        // Test 5: reset in the middle of a burst, with winc still high.
        step(1'b1, 1'b0, 5'd0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 5'd0);
        chk("t5_pre_waddr",  32'(bus.waddr),  32'd5);
        chk("t5_pre_wlevel", 32'(bus.wlevel), 32'd5);
        step(1'b1, 1'b1, 5'd0);
        chk("t5_rst_wptr",   32'(bus.wptr),   32'd0);
        chk("t5_rst_waddr",  32'(bus.waddr),  32'd0);
        chk("t5_rst_wlevel", 32'(bus.wlevel), 32'd0);
        chk("t5_rst_wfull",  32'(bus.wfull),  32'd0);
        chk("t5_rst_wclk_en", 32'(bus.wclk_en), 32'd1);
        step(1'b0, 1'b1, 5'd0);
        chk("t5_next_waddr", 32'(bus.waddr), 32'd1);
        chk("t5_next_wptr",  32'(bus.wptr),  32'd1);
        chk("t5_next_wlevel", 32'(bus.wlevel), 32'd1);
        chk("t5_walmost",    32'(bus.walmost_full), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
